// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: operand widths and
// the operation encoding presented by the decode stage.
package hilo_unit_pkg;

  typedef logic [31:0] i32;
  typedef logic [63:0] i64;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_t;

  // Two's-complement magnitude; 0x80000000 maps to itself and is read as unsigned.
  function automatic i32 abs32(input i32 v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv.sv
// Unsigned iterative restoring divider: one quotient bit per clock, 32 cycles
// after valid; c = {remainder, quotient} is held stable after done pulses.
module multdiv
  import hilo_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] c
);

  i32           r_quot;
  i32           r_rem;
  logic [4:0]   r_count;
  logic         r_busy;
  logic         r_done;

  logic [32:0]  w_shift;
  logic         w_ge;
  logic [32:0]  w_sub;

  // Partial remainder is always < b, so the shifted value fits in 33 bits.
  assign w_shift = {r_rem, r_quot[31]};
  assign w_ge    = (w_shift >= {1'b0, b});
  assign w_sub   = w_shift - {1'b0, b};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_quot  <= '0;
      r_rem   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (valid) begin
        r_quot  <= a;
        r_rem   <= '0;
        r_count <= '0;
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        r_quot  <= {r_quot[30:0], w_ge};
        r_rem   <= w_ge ? w_sub[31:0] : w_shift[31:0];
        r_count <= r_count + 5'd1;
        if (r_count == 5'd31) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done = r_done;
  assign c    = {r_rem, r_quot};

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: MTHI/MTLO, single-pass 64-bit multiply, and signed or
// unsigned divide built around the iterative multdiv core.
module hilo_unit
  import hilo_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_MUL        = 3'd1;
  localparam logic [2:0] S_DIV_LAUNCH = 3'd2;
  localparam logic [2:0] S_DIV_WAIT   = 3'd3;
  localparam logic [2:0] S_DIV_FIX    = 3'd4;

  logic [2:0]  r_state;
  i32          r_hi;
  i32          r_lo;
  i32          r_op_a;
  i32          r_op_b;
  logic        r_signed;
  logic        r_neg_q;
  logic        r_neg_r;

  mdu_op_t     w_op;
  logic        w_accept;
  logic        w_is_div;
  logic        w_div_zero;
  logic        w_md_valid;
  logic        w_md_done;
  i64          w_md_c;
  logic        w_md_resetn;
  logic signed [32:0] w_mul_a;
  logic signed [32:0] w_mul_b;
  logic signed [63:0] w_prod;
  i32          w_quot;
  i32          w_rem;

  assign w_op       = mdu_op_t'(req_op);
  assign req_ready  = (r_state == S_IDLE) & ~flush;
  assign w_accept   = req_valid & req_ready;
  assign w_is_div   = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
  assign w_div_zero = w_accept & w_is_div & (req_b == 32'd0);
  assign w_md_valid = (r_state == S_DIV_LAUNCH);
  assign w_md_resetn = ~(reset | flush);

  // Operands extended to 33 bits so one signed multiplier covers MULT and MULTU.
  assign w_mul_a = {r_signed & r_op_a[31], r_op_a};
  assign w_mul_b = {r_signed & r_op_b[31], r_op_b};
  assign w_prod  = w_mul_a * w_mul_b;

  assign w_quot = r_neg_q ? (~w_md_c[31:0]  + 32'd1) : w_md_c[31:0];
  assign w_rem  = r_neg_r ? (~w_md_c[63:32] + 32'd1) : w_md_c[63:32];

  multdiv u_multdiv (
    .clk    (clk),
    .resetn (w_md_resetn),
    .valid  (w_md_valid),
    .a      (r_op_a),
    .b      (r_op_b),
    .done   (w_md_done),
    .c      (w_md_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (w_op)
              MDU_MTHI: r_hi <= req_a;
              MDU_MTLO: r_lo <= req_a;
              MDU_MULT, MDU_MULTU: begin
                r_op_a   <= req_a;
                r_op_b   <= req_b;
                r_signed <= (w_op == MDU_MULT);
                r_state  <= S_MUL;
              end
              MDU_DIV, MDU_DIVU: begin
                if (req_b != 32'd0) begin
                  r_op_a  <= abs32(req_a, w_op == MDU_DIV);
                  r_op_b  <= abs32(req_b, w_op == MDU_DIV);
                  r_neg_q <= (w_op == MDU_DIV) & (req_a[31] ^ req_b[31]);
                  r_neg_r <= (w_op == MDU_DIV) & req_a[31];
                  r_state <= S_DIV_LAUNCH;
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          {r_hi, r_lo} <= w_prod;
          r_state      <= S_IDLE;
        end
        S_DIV_LAUNCH: r_state <= S_DIV_WAIT;
        S_DIV_WAIT:   if (w_md_done) r_state <= S_DIV_FIX;
        S_DIV_FIX: begin
          r_lo    <= w_quot;
          r_hi    <= w_rem;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);

  // Asserted in the cycle whose closing edge writes hi/lo (or would, for divide-by-zero).
  assign resp_valid = ~reset & ~flush &
                      ((w_accept & ((w_op == MDU_MTHI) || (w_op == MDU_MTLO) || w_div_zero)) |
                       (r_state == S_MUL) | (r_state == S_DIV_FIX));

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameters: none; all widths are fixed by package typedefs.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 flush  in  1  pipeline flush; cancels any operation in progress.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  unit can accept a request this cycle.
REQ-007 req_op  in  3  mdu_op_t: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-008 req_a  in  32  rs operand: dividend, multiplicand, or MTHI/MTLO source.
REQ-009 req_b  in  32  rt operand: divisor or multiplier.
REQ-010 busy  out  1  stall request to the pipeline; high whenever state != IDLE.
REQ-011 resp_valid  out  1  one-cycle pulse in the cycle that hi/lo are written.
REQ-012 hi, lo  out  32 each  architectural HI/LO registers, driven directly from flops.

Function
REQ-013 Accept SHALL occur when req_valid & req_ready; req_ready = (state==IDLE) & ~flush.
REQ-014 FSM states SHALL be IDLE, MUL, DIV_LAUNCH, DIV_WAIT, DIV_FIX; reset state is IDLE.
REQ-015 MTHI/MTLO accepted in IDLE SHALL write hi/lo at that clock edge, stay in IDLE, and pulse resp_valid in the accept cycle.
REQ-016 MULT/MULTU SHALL register the operands and the signed flag, then go to MUL.
REQ-017 MUL SHALL compute the 64-bit product (signed or unsigned), write {hi,lo}, pulse resp_valid, and return to IDLE; accept-to-visible latency is 2 edges.
REQ-018 DIV/DIVU with req_b != 0 SHALL register |a|, |b| (raw values for DIVU), plus sign flags neg_q = a[31]^b[31] and neg_r = a[31] (both 0 for DIVU), then go to DIV_LAUNCH.
REQ-019 DIV_LAUNCH SHALL assert md_valid for exactly one cycle, then go to DIV_WAIT.
REQ-020 Registered operands SHALL stay stable on the sub-module inputs from DIV_LAUNCH until DIV_FIX.
REQ-021 DIV_WAIT SHALL hold until md_done, then go to DIV_FIX.
REQ-022 DIV_FIX SHALL read sub-module c = {rem, quot}, negate quot if neg_q and rem if neg_r, write lo = quot and hi = rem, pulse resp_valid, and return to IDLE.
REQ-023 Division by zero SHALL leave hi/lo unchanged, skip the sub-module, pulse resp_valid in the accept cycle, and stay in IDLE.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo = 0x80000000, hi = 0 (the magnitude 0x80000000 is treated as unsigned).
REQ-025 NONE, or req_valid with req_ready low, SHALL have no effect.
REQ-026 flush in any state SHALL force IDLE at the next edge with no hi/lo write and no resp_valid; flush SHALL override a simultaneous completion.
REQ-027 The sub-module SHALL be held in reset while reset | flush, so that a following DIV starts cleanly.
REQ-028 Divide completion SHALL occur within 40 cycles of accept.

Reset
REQ-029 On reset: state = IDLE; hi = lo = 0; busy = 0; resp_valid = 0; md_valid = 0; operand registers = 0.
REQ-030 Reset mid-operation SHALL discard the operation, with hi/lo cleared regardless.

Structure
REQ-031 mdu_op_t and the i32/i64 typedefs SHALL live in the shared defs package; the FSM state enum stays local to the module.
REQ-032 The module SHALL instantiate exactly one sub-module, multdiv, the team's unsigned iterative divider.
REQ-033 multdiv connections: resetn = ~(reset|flush), valid = md_valid, a = |a|, b = |b|, done = md_done, c = {rem, quot}.
REQ-034 Multiplication SHALL be done in this module (one 64-bit multiply), not in the sub-module.

Verification
REQ-035 MULT 0xFFFFFFFE x 3 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFA after 2 edges; MULTU with the same operands -> hi = 0x00000002, lo = 0xFFFFFFFA.
REQ-036 DIV -7/2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 7/2 -> lo = 3, hi = 1; busy high throughout and resp_valid a single pulse.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0; DIV 5/0 with hi = lo = 0x1234 beforehand -> both unchanged, resp_valid in the accept cycle.
REQ-038 DIVU 1000/3 flushed 10 cycles after accept -> IDLE next edge, hi/lo unchanged; then DIVU 100/7 -> lo = 14, hi = 2.
REQ-039 MTHI 0xDEAD presented while busy -> req_ready = 0, not written; the same request presented in IDLE -> hi = 0xDEAD at the next edge.
REQ-040 reset asserted mid-divide -> hi = lo = 0, busy = 0 next cycle; a subsequent DIV 9/-2 -> lo = 0xFFFFFFFC, hi = 1.
